// File: rtl/ibex_fp_seq_if.sv
// ibex_fp_seq_if -- bundle for the FP sequencer. It carries three groups of
// signals:
//   - the ID handshake
//   - the FPU request/response
//   - the result and sticky fflags outputs
//
// Modports:
//   slave   the sequencer. It receives the ID and FPU inputs and drives
//           the FPU request and the results.
//   master  the environment, i.e. ID plus the FPU.

interface ibex_fp_seq_if;
  logic                 fp_en_i;
  logic                 fp_sel_i;
  ibex_pkg::fp_alu_op_e fp_operator_i;
  logic [15:0]          fp_operand_a_i;
  logic [15:0]          fp_operand_b_i;
  logic                 fp_ready_id_i;
  logic                 fp_kill_i;
  logic                 fflags_clr_i;
  logic                 fpu_start_o;
  ibex_pkg::fp_alu_op_e fpu_op_o;
  logic [15:0]          fpu_a_o;
  logic [15:0]          fpu_b_o;
  logic [15:0]          fpu_result_i;
  logic [4:0]           fpu_flags_i;
  logic [31:0]          fp_result_o;
  logic                 fp_valid_o;
  logic                 fp_busy_o;
  logic [4:0]           fflags_o;

  modport slave (
    input  fp_en_i, fp_sel_i, fp_operator_i, fp_operand_a_i, fp_operand_b_i,
    input  fp_ready_id_i, fp_kill_i, fflags_clr_i, fpu_result_i, fpu_flags_i,
    output fpu_start_o, fpu_op_o, fpu_a_o, fpu_b_o,
    output fp_result_o, fp_valid_o, fp_busy_o, fflags_o
  );

  modport master (
    output fp_en_i, fp_sel_i, fp_operator_i, fp_operand_a_i, fp_operand_b_i,
    output fp_ready_id_i, fp_kill_i, fflags_clr_i, fpu_result_i, fpu_flags_i,
    input  fpu_start_o, fpu_op_o, fpu_a_o, fpu_b_o,
    input  fp_result_o, fp_valid_o, fp_busy_o, fflags_o
  );
endinterface

// File: rtl/ibex_fp_seq.sv
// ibex_fp_seq -- sequencer for the multi-cycle bfloat16 FPU in the EX stage.
//
// Takes one FP operation at a time from ID using the enable/select/ready
// handshake shared with the mult/div unit. It registers the operator and
// operands, pulses the FPU start, counts the per-class latency, and holds
// the captured result until ID takes it. A kill abandons the operation in
// flight. Exception flags of retired operations are accumulated as sticky
// fflags.
//
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous reset, active low
//   bus     ibex_fp_seq_if.slave, which carries:
//           - the ID handshake
//           - the FPU request/response
//           - the result and fflags outputs
//
// The package below supplies the FP operator enumeration shared with the
// interface and with ID.

package ibex_pkg;
  typedef enum logic [2:0] {
    FP_ADD = 3'd0,
    FP_SUB = 3'd1,
    FP_MUL = 3'd2,
    FP_DIV = 3'd3,
    FP_MIN = 3'd4,
    FP_MAX = 3'd5,
    FP_CMP = 3'd6,
    FP_CVT = 3'd7
  } fp_alu_op_e;
endpackage

module ibex_fp_seq #(
  parameter int unsigned AddLat = 2,
  parameter int unsigned MulLat = 3,
  parameter int unsigned DivLat = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  ibex_fp_seq_if.slave bus
);
  import ibex_pkg::*;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e     r_state;
  state_e     w_state_nxt;
  logic [3:0] r_cnt;
  logic       r_start;
  fp_alu_op_e r_op;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_res;
  logic [4:0]  r_fcap;
  logic [4:0]  r_fflags;
  logic        w_accept;
  logic        w_capture;
  logic        w_retire;

  // The counter is preloaded with latency-1 so that it reaches zero in the
  // last BUSY cycle, which is the cycle in which the FPU result is sampled.
  function automatic logic [3:0] lat_m1(input fp_alu_op_e op);
    logic [3:0] v;
    case (op)
      FP_MUL:  v = 4'(MulLat - 1);
      FP_DIV:  v = 4'(DivLat - 1);
      default: v = 4'(AddLat - 1);
    endcase
    return v;
  endfunction

  // Next-state logic and the accept/capture/retire strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.fp_en_i && bus.fp_sel_i && !bus.fp_kill_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (bus.fp_kill_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      S_DONE: begin
        // When both kill and ready are set, kill wins and the flags are
        // dropped.
        if (bus.fp_kill_i) begin
          w_state_nxt = S_IDLE;
        end else if (bus.fp_ready_id_i) begin
          w_retire    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request capture, start pulse and latency counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op    <= FP_ADD;
      r_a     <= 16'h0000;
      r_b     <= 16'h0000;
      r_cnt   <= 4'd0;
      r_start <= 1'b0;
    end else begin
      r_start <= w_accept;
      if (w_accept) begin
        r_op  <= bus.fp_operator_i;
        r_a   <= bus.fp_operand_a_i;
        r_b   <= bus.fp_operand_b_i;
        r_cnt <= lat_m1(bus.fp_operator_i);
      end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // FPU response capture and sticky flag accumulation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_res    <= 16'h0000;
      r_fcap   <= 5'b00000;
      r_fflags <= 5'b00000;
    end else begin
      if (w_capture) begin
        r_res  <= bus.fpu_result_i;
        r_fcap <= bus.fpu_flags_i;
      end else begin
        r_res  <= r_res;
        r_fcap <= r_fcap;
      end
      // When a clear coincides with a retirement, the retiring flags
      // replace the old ones instead of being dropped.
      if (w_retire) begin
        r_fflags <= bus.fflags_clr_i ? r_fcap : (r_fflags | r_fcap);
      end else if (bus.fflags_clr_i) begin
        r_fflags <= 5'b00000;
      end else begin
        r_fflags <= r_fflags;
      end
    end
  end

  // A kill arriving in the first BUSY cycle suppresses the start pulse,
  // so the FPU never sees a start for an abandoned operation.
  assign bus.fpu_start_o = r_start & ~bus.fp_kill_i;
  assign bus.fpu_op_o    = r_op;
  assign bus.fpu_a_o     = r_a;
  assign bus.fpu_b_o     = r_b;
  assign bus.fp_valid_o  = (r_state == S_DONE);
  assign bus.fp_busy_o   = (r_state != S_IDLE);
  assign bus.fp_result_o = (r_state == S_DONE) ? {16'h0000, r_res} : 32'h0000_0000;
  assign bus.fflags_o    = r_fflags;

endmodule

// File: tb/tb_ibex_fp_seq.sv
// tb_ibex_fp_seq -- directed, scoreboard-based bench for ibex_fp_seq.
// The FPU model presents the real result/flags only in the cycle in which
// the sequencer must sample them and garbage otherwise.
module tb_ibex_fp_seq;
  import ibex_pkg::*;

  localparam int unsigned ADD_L = 2;
  localparam int unsigned MUL_L = 3;
  localparam int unsigned DIV_L = 8;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cap_cyc = -1;
  logic [15:0] m_res   = 16'h0000;
  logic [4:0]  m_flags = 5'b00000;

  typedef struct {
    logic [31:0] res;
    int          vcyc;
  } sb_t;
  sb_t sb[$];

  ibex_fp_seq_if bus();

  ibex_fp_seq #(.AddLat(ADD_L), .MulLat(MUL_L), .DivLat(DIV_L)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  assign bus.fpu_result_i = (cyc == cap_cyc) ? m_res : 16'hBAD0;
  assign bus.fpu_flags_i  = (cyc == cap_cyc) ? m_flags : 5'b11111;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request in the current cycle (accept cycle T) and arm the FPU
  // model to answer in cycle T+lat. Returns in cycle T+1.
  task automatic issue(input fp_alu_op_e op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] res, input logic [4:0] fl, input int lat,
                       input bit push);
    sb_t e;
    bus.fp_en_i        = 1'b1;
    bus.fp_sel_i       = 1'b1;
    bus.fp_operator_i  = op;
    bus.fp_operand_a_i = a;
    bus.fp_operand_b_i = b;
    cap_cyc = cyc + lat;
    m_res   = res;
    m_flags = fl;
    if (push) begin
      e.res  = {16'h0000, res};
      e.vcyc = cyc + 1 + lat;
      sb.push_back(e);
    end
    tick();
    bus.fp_en_i  = 1'b0;
    bus.fp_sel_i = 1'b0;
  endtask

  task automatic wait_valid();
    sb_t e;
    int  n;
    n = 0;
    while (bus.fp_valid_o !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("valid_seen", 32'(bus.fp_valid_o), 32'd1);
    if (bus.fp_valid_o === 1'b1) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("result", bus.fp_result_o, e.res);
        chk("valid_cycle", 32'(cyc), 32'(e.vcyc));
      end else begin
        chk("unexpected_valid", 32'(sb.size()), 32'd1);
      end
    end
  endtask

  task automatic retire();
    wait_valid();
    bus.fp_ready_id_i = 1'b1;
    tick();
    bus.fp_ready_id_i = 1'b0;
    chk("idle_after_retire", 32'(bus.fp_busy_o), 32'd0);
    chk("result_zero_idle", bus.fp_result_o, 32'h0);
  endtask

  initial begin
    bus.fp_en_i        = 1'b0;
    bus.fp_sel_i       = 1'b0;
    bus.fp_operator_i  = FP_ADD;
    bus.fp_operand_a_i = 16'h0000;
    bus.fp_operand_b_i = 16'h0000;
    bus.fp_ready_id_i  = 1'b0;
    bus.fp_kill_i      = 1'b0;
    bus.fflags_clr_i   = 1'b0;

    // Reset state.
    tick();
    tick();
    chk("rst_busy", 32'(bus.fp_busy_o), 32'd0);
    chk("rst_valid", 32'(bus.fp_valid_o), 32'd0);
    chk("rst_start", 32'(bus.fpu_start_o), 32'd0);
    chk("rst_fflags", 32'(bus.fflags_o), 32'd0);
    chk("rst_result", bus.fp_result_o, 32'h0);
    rst_ni = 1'b1;
    tick();

    // Test 1: ADD, latency 2.
    issue(FP_ADD, 16'h3F80, 16'h4000, 16'h4040, 5'b00000, ADD_L, 1'b1);
    chk("t1_start", 32'(bus.fpu_start_o), 32'd1);
    chk("t1_busy", 32'(bus.fp_busy_o), 32'd1);
    chk("t1_a", 32'(bus.fpu_a_o), 32'h3F80);
    chk("t1_b", 32'(bus.fpu_b_o), 32'h4000);
    chk("t1_op", 32'(bus.fpu_op_o), 32'(FP_ADD));
    tick();
    chk("t1_start_once", 32'(bus.fpu_start_o), 32'd0);
    chk("t1_not_valid", 32'(bus.fp_valid_o), 32'd0);
    retire();
    chk("t1_fflags", 32'(bus.fflags_o), 32'd0);

    // Test 2: DIV, latency 8, busy for cycles T+1..T+9.
    issue(FP_DIV, 16'h3F80, 16'h4000, 16'h3F00, 5'b00000, DIV_L, 1'b1);
    chk("t2_op", 32'(bus.fpu_op_o), 32'(FP_DIV));
    for (int i = 1; i <= 8; i++) begin
      chk("t2_busy", 32'(bus.fp_busy_o), 32'd1);
      chk("t2_not_valid", 32'(bus.fp_valid_o), 32'd0);
      tick();
    end
    chk("t2_busy_done", 32'(bus.fp_busy_o), 32'd1);
    retire();

    // Test 3: DONE held with en high, then back-to-back accept.
    issue(FP_MUL, 16'h4000, 16'h4040, 16'h40C0, 5'b00100, MUL_L, 1'b1);
    wait_valid();
    bus.fp_en_i        = 1'b1;
    bus.fp_sel_i       = 1'b1;
    bus.fp_operator_i  = FP_SUB;
    bus.fp_operand_a_i = 16'h1111;
    bus.fp_operand_b_i = 16'h2222;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_valid_hold", 32'(bus.fp_valid_o), 32'd1);
      chk("t3_result_hold", bus.fp_result_o, 32'h0000_40C0);
      chk("t3_no_start", 32'(bus.fpu_start_o), 32'd0);
      chk("t3_a_hold", 32'(bus.fpu_a_o), 32'h4000);
    end
    bus.fp_ready_id_i = 1'b1;
    tick();
    bus.fp_ready_id_i = 1'b0;
    chk("t3_idle", 32'(bus.fp_busy_o), 32'd0);
    chk("t3_fflags", 32'(bus.fflags_o), 32'b00100);
    issue(FP_SUB, 16'h1111, 16'h2222, 16'h3333, 5'b00000, ADD_L, 1'b1);
    chk("t3_next_start", 32'(bus.fpu_start_o), 32'd1);
    chk("t3_next_a", 32'(bus.fpu_a_o), 32'h1111);
    chk("t3_next_op", 32'(bus.fpu_op_o), 32'(FP_SUB));
    retire();

    // Test 4: MUL killed at T+2.
    issue(FP_MUL, 16'h4000, 16'h4000, 16'h4080, 5'b10000, MUL_L, 1'b0);
    tick();
    bus.fp_kill_i = 1'b1;
    tick();
    bus.fp_kill_i = 1'b0;
    chk("t4_idle", 32'(bus.fp_busy_o), 32'd0);
    chk("t4_not_valid", 32'(bus.fp_valid_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_never_valid", 32'(bus.fp_valid_o), 32'd0);
    end
    chk("t4_fflags", 32'(bus.fflags_o), 32'b00100);

    // Kill in the first BUSY cycle suppresses the start pulse.
    issue(FP_ADD, 16'h3F80, 16'h3F80, 16'h4000, 5'b00000, ADD_L, 1'b0);
    bus.fp_kill_i = 1'b1;
    #1;
    chk("t4_kill_start", 32'(bus.fpu_start_o), 32'd0);
    tick();
    bus.fp_kill_i = 1'b0;
    chk("t4_kill_first_idle", 32'(bus.fp_busy_o), 32'd0);

    // Kill and ready together in DONE: no flag update.
    issue(FP_ADD, 16'h3F80, 16'h3F80, 16'h4000, 5'b10000, ADD_L, 1'b1);
    wait_valid();
    bus.fp_kill_i     = 1'b1;
    bus.fp_ready_id_i = 1'b1;
    tick();
    bus.fp_kill_i     = 1'b0;
    bus.fp_ready_id_i = 1'b0;
    chk("t4_kr_idle", 32'(bus.fp_busy_o), 32'd0);
    chk("t4_kr_fflags", 32'(bus.fflags_o), 32'b00100);

    // Test 5: sticky flags, clear, clear-with-retire.
    bus.fflags_clr_i = 1'b1;
    tick();
    bus.fflags_clr_i = 1'b0;
    chk("t5_clr0", 32'(bus.fflags_o), 32'd0);
    issue(FP_DIV, 16'h3F80, 16'h0000, 16'h7F80, 5'b01000, DIV_L, 1'b1);
    retire();
    chk("t5_dz", 32'(bus.fflags_o), 32'b01000);
    bus.fflags_clr_i = 1'b1;
    tick();
    bus.fflags_clr_i = 1'b0;
    chk("t5_clr1", 32'(bus.fflags_o), 32'd0);
    issue(FP_MUL, 16'h3F80, 16'h3F80, 16'h3F80, 5'b00001, MUL_L, 1'b1);
    wait_valid();
    bus.fp_ready_id_i = 1'b1;
    bus.fflags_clr_i  = 1'b1;
    tick();
    bus.fp_ready_id_i = 1'b0;
    bus.fflags_clr_i  = 1'b0;
    chk("t5_clr_retire", 32'(bus.fflags_o), 32'b00001);
    issue(FP_MAX, 16'h3F80, 16'h4000, 16'h4000, 5'b10000, ADD_L, 1'b1);
    retire();
    chk("t5_accum", 32'(bus.fflags_o), 32'b10001);

    // Test 6: asynchronous reset in BUSY.
    issue(FP_DIV, 16'h4040, 16'h4000, 16'h3FC0, 5'b00010, DIV_L, 1'b0);
    tick();
    tick();
    rst_ni = 1'b0;
    #1;
    chk("t6_busy", 32'(bus.fp_busy_o), 32'd0);
    chk("t6_valid", 32'(bus.fp_valid_o), 32'd0);
    chk("t6_start", 32'(bus.fpu_start_o), 32'd0);
    chk("t6_a", 32'(bus.fpu_a_o), 32'd0);
    chk("t6_b", 32'(bus.fpu_b_o), 32'd0);
    chk("t6_op", 32'(bus.fpu_op_o), 32'd0);
    chk("t6_fflags", 32'(bus.fflags_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    issue(FP_ADD, 16'h4000, 16'h4000, 16'h4080, 5'b00000, ADD_L, 1'b1);
    chk("t6_start_after", 32'(bus.fpu_start_o), 32'd1);
    retire();
    chk("t6_fflags_after", 32'(bus.fflags_o), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
